// File: rtl/pipelined_rca.sv
// pipelined_rca: pipelined ripple-carry adder/subtractor with valid/ready handshake
// Optional feature macro: PIPELINED_RCA_OVERFLOW_EN (adds ovf output)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand beat handshake
//   a, b, c_in, sub      operands, carry-in, subtract mode (b inverted)
//   out_valid, out_ready result beat handshake
//   sum, c_out           WIDTH-bit result and carry out of the MSB
//   ovf                  signed overflow flag (only with PIPELINED_RCA_OVERFLOW_EN)
`timescale 1ns/1ps
module pipelined_rca #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PIPELINED_RCA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int SLICE = WIDTH / STAGES;
  logic             adv;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] aq [STAGES];
  logic [WIDTH-1:0] bq [STAGES];
  logic [WIDTH-1:0] sq [STAGES];
  logic [STAGES-1:0] cq, vq;
  logic [WIDTH-1:0] ia [STAGES];
  logic [WIDTH-1:0] ib [STAGES];
  logic [WIDTH-1:0] ip [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [STAGES-1:0] ic, iv;
  logic [SLICE:0]   r [STAGES];
  // Whole pipe moves in lockstep; bubbles are not squeezed out.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  // Subtraction inverts b once at entry; the inverted operand travels down the pipe.
  assign bx        = sub ? ~b : b;
  assign out_valid = vq[STAGES-1];
  assign sum       = sq[STAGES-1];
  assign c_out     = cq[STAGES-1];
  // Stage k sees either the ports (k=0) or the register of stage k-1 and ripples one slice.
  always_comb begin
    ia[0] = a;
    ib[0] = bx;
    ic[0] = c_in;
    iv[0] = in_valid;
    ip[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      ia[k] = aq[k-1];
      ib[k] = bq[k-1];
      ic[k] = cq[k-1];
      iv[k] = vq[k-1];
      ip[k] = sq[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r[k] = {1'b0, ia[k][k*SLICE +: SLICE]} + {1'b0, ib[k][k*SLICE +: SLICE]} + {{SLICE{1'b0}}, ic[k]};
      ns[k] = ip[k];
      ns[k][k*SLICE +: SLICE] = r[k][SLICE-1:0];
    end
  end
`ifdef PIPELINED_RCA_OVERFLOW_EN
  logic ovf_n;
  // Carry into the MSB recovered as sum ^ a ^ b at that bit, so no extra split adder is needed.
  assign ovf_n = r[STAGES-1][SLICE] ^ ns[STAGES-1][WIDTH-1] ^ ia[STAGES-1][WIDTH-1] ^ ib[STAGES-1][WIDTH-1];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq <= '0;
      cq <= '0;
      for (int k = 0; k < STAGES; k++) begin
        aq[k] <= '0;
        bq[k] <= '0;
        sq[k] <= '0;
      end
`ifdef PIPELINED_RCA_OVERFLOW_EN
      ovf <= 1'b0;
`endif
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vq[k] <= iv[k];
        cq[k] <= r[k][SLICE];
        aq[k] <= ia[k];
        bq[k] <= ib[k];
        sq[k] <= ns[k];
      end
`ifdef PIPELINED_RCA_OVERFLOW_EN
      ovf <= ovf_n;
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed vector table plus multi-cycle handshake/reset sequences for pipelined_rca
`timescale 1ns/1ps
module tb_pipelined_rca;
  localparam int W = 64;
  localparam int S = 4;
  logic         clk = 0;
  logic         rst_n;
  logic         in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
  logic [W-1:0] a, b, sum;
  logic         ovf_v;
`ifdef PIPELINED_RCA_OVERFLOW_EN
  logic         ovf;
  assign ovf_v = ovf;
`else
  assign ovf_v = 1'b0;
`endif
  int errors = 0;
  int checks = 0;
  pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out)
`ifdef PIPELINED_RCA_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;
  vec_t vecs [11];
  logic [W+1:0] exp_q [$];
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, input logic vs);
    in_valid = 1'b1;
    a = va;
    b = vb;
    c_in = vc;
    sub = vs;
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, input logic vs);
    logic [W-1:0] bb;
    logic [W:0] t;
    bb = vs ? ~vb : vb;
    t = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, vc};
    return {(va[W-1] == bb[W-1]) && (t[W-1] != va[W-1]), t};
  endfunction
  initial begin
    vecs[0]  = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 0, 0, 64'h0, 1, 0};
    vecs[1]  = '{64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA, 0, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0};
    vecs[2]  = '{64'h123456789ABCDEF0, 64'hFEDCBA9876543210, 1, 0, 64'h1111111111111101, 1, 0};
    vecs[3]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0};
    vecs[4]  = '{64'h10, 64'h3, 1, 1, 64'hD, 1, 0};
    vecs[5]  = '{64'h3, 64'h10, 1, 1, 64'hFFFFFFFFFFFFFFF3, 0, 0};
    vecs[6]  = '{64'h0, 64'h0, 0, 0, 64'h0, 0, 0};
    vecs[7]  = '{64'h5, 64'h5, 0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 0};
    vecs[8]  = '{64'h00000000FFFFFFFF, 64'h1, 0, 0, 64'h0000000100000000, 0, 0};
    vecs[9]  = '{64'h7FFFFFFFFFFFFFFF, 64'h1, 0, 0, 64'h8000000000000000, 0, 1};
    vecs[10] = '{64'h8000000000000000, 64'h1, 1, 1, 64'h7FFFFFFFFFFFFFFF, 1, 1};
    rst_n = 0; in_valid = 0; a = 0; b = 0; c_in = 0; sub = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", {63'd0, c_out}, 0);
    rst_n = 1;
    #1 chk("rst_in_ready", {63'd0, in_ready}, 1);
    // single beats: exact latency and result
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      #1 chk("vec_in_ready", {63'd0, in_ready}, 1);
      for (int c = 1; c <= S; c++) begin
        @(negedge clk);
        in_valid = 0;
        if (c < S) chk($sformatf("vec%0d_early_valid", i), {63'd0, out_valid}, 0);
        else begin
          chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 1);
          chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
          chk($sformatf("vec%0d_c_out", i), {63'd0, c_out}, {63'd0, vecs[i].cout});
`ifdef PIPELINED_RCA_OVERFLOW_EN
          chk($sformatf("vec%0d_ovf", i), {63'd0, ovf_v}, {63'd0, vecs[i].ovf});
`endif
        end
      end
    end
    // full-rate stream: vectors 1..3 back to back
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 3) drive(vecs[c+1].a, vecs[c+1].b, vecs[c+1].cin, vecs[c+1].sub);
      else in_valid = 0;
      if (c >= S && c < S + 3) begin
        chk("stream_valid", {63'd0, out_valid}, 1);
        chk("stream_sum", sum, vecs[c-S+1].sum);
        chk("stream_c_out", {63'd0, c_out}, {63'd0, vecs[c-S+1].cout});
      end else chk("stream_bubble", {63'd0, out_valid}, 0);
    end
    // backpressure: six beats, output stalled for three cycles from first out_valid
    begin
      int idx = 0;
      logic acc;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        out_ready = !(c >= 4 && c <= 6);
        if (idx < 6) drive(W'(idx + 1), W'(idx + 1), 0, 0);
        else in_valid = 0;
        #1;
        acc = in_valid & in_ready;
        if (c >= 4 && c <= 6) begin
          chk("bp_stall_in_ready", {63'd0, in_ready}, 0);
          chk("bp_stall_valid", {63'd0, out_valid}, 1);
          chk("bp_stall_sum", sum, 2);
        end else if (c >= 7 && c <= 12) begin
          chk("bp_valid", {63'd0, out_valid}, 1);
          chk("bp_sum", sum, W'(2 * (c - 6)));
        end else if (c == 13) chk("bp_drained", {63'd0, out_valid}, 0);
        @(posedge clk);
        if (acc) idx++;
      end
      chk("bp_all_accepted", W'(idx), 6);
    end
    // reset mid-flight
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(W'(c + 7), W'(1), 0, 0);
    end
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1 chk("midrst_valid", {63'd0, out_valid}, 0);
    chk("midrst_sum", sum, 0);
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("midrst_no_stale", {63'd0, out_valid}, 0);
    end
    drive(64'h100, 64'h23, 0, 0);
    for (int c = 1; c <= S; c++) begin
      @(negedge clk);
      in_valid = 0;
      if (c < S) chk("midrst_early", {63'd0, out_valid}, 0);
      else begin
        chk("midrst_valid_after", {63'd0, out_valid}, 1);
        chk("midrst_sum_after", sum, 64'h123);
      end
    end
    // random scoreboard sweep with random stalls
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      out_ready = (c >= 2900) || ($urandom_range(0, 3) != 0);
      if (c < 2880 && $urandom_range(0, 4) != 0)
        drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      else in_valid = 0;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_beat", {63'd0, out_valid}, 0);
        else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          chk("rnd_sum", sum, e[W-1:0]);
          chk("rnd_c_out", {63'd0, c_out}, {63'd0, e[W]});
`ifdef PIPELINED_RCA_OVERFLOW_EN
          chk("rnd_ovf", {63'd0, ovf_v}, {63'd0, e[W+1]});
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
    end
    chk("rnd_drained", W'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
